mat3_vec_seq: RTL and testbench

Initiator/sequencer for the dp_3x1 dot-product unit. It takes a 3x3 rotation matrix and a 3x1 platform point, then issues the three row dot products to dp_3x1 over its validIn/operand interface. It collects the three dp/validOut results in order and presents the rotated vector (qx, qy, qz) with a done pulse. It sits between the ball-and-plate kinematics controller and a shared dp_3x1 instance.

---
 rtl/mat3_vec_seq_pkg.sv | 14 +
 rtl/mat3_vec_seq.sv | 195 +++++++++++++++++++
 tb/tb_mat3_vec_seq.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mat3_vec_seq_pkg.sv
// Shared constants for the 3x3 matrix by 3x1 vector sequencer: state encodings
// and fixed-point scale factors for the operand formats.
package mat3_vec_seq_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_COLLECT = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // 1.0 in the matrix (Q2.16) and point (Q8.10) formats
   localparam logic [17:0] ONE_Q2_16 = 18'h10000;
   localparam logic [17:0] ONE_Q8_10 = 18'h00400;

endpackage

// File: rtl/mat3_vec_seq.sv
// Issues the three row dot products of R*p to an external dp_3x1 unit and
// gathers its results, in order, into qx/qy/qz.
module mat3_vec_seq
   import mat3_vec_seq_pkg::*;
#(
   parameter int A_WIDTH  = 18,
   parameter int B_WIDTH  = 18,
   parameter int MAX_WAIT = 64
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [9*A_WIDTH-1:0]         R_flat,
   input  logic [B_WIDTH-1:0]           px,
   input  logic [B_WIDTH-1:0]           py,
   input  logic [B_WIDTH-1:0]           pz,
   output logic                         busy,
   output logic                         done,
   output logic                         timeout,
   output logic [A_WIDTH+B_WIDTH:0]     qx,
   output logic [A_WIDTH+B_WIDTH:0]     qy,
   output logic [A_WIDTH+B_WIDTH:0]     qz,
   output logic                         dp_validIn,
   output logic [A_WIDTH-1:0]           dp_A1,
   output logic [A_WIDTH-1:0]           dp_A2,
   output logic [A_WIDTH-1:0]           dp_A3,
   output logic [B_WIDTH-1:0]           dp_B1,
   output logic [B_WIDTH-1:0]           dp_B2,
   output logic [B_WIDTH-1:0]           dp_B3,
   input  logic [A_WIDTH+B_WIDTH:0]     dp_dp,
   input  logic                         dp_validOut
);

   localparam int P_WIDTH = A_WIDTH + B_WIDTH + 1;
   localparam int W_WIDTH = $clog2(MAX_WAIT + 1);

   function automatic logic [A_WIDTH-1:0] elem(input logic [9*A_WIDTH-1:0] m,
                                               input int unsigned r,
                                               input int unsigned c);
      return m[(3*r+c)*A_WIDTH +: A_WIDTH];
   endfunction

   logic [1:0]             state_q, state_d;
   logic [9*A_WIDTH-1:0]   mat_q, mat_d;
   logic [B_WIDTH-1:0]     px_q, px_d, py_q, py_d, pz_q, pz_d;
   logic [1:0]             issue_q, issue_d, res_q, res_d;
   logic [W_WIDTH-1:0]     wait_q, wait_d;
   logic [P_WIDTH-1:0]     r0_q, r0_d, r1_q, r1_d;
   logic [P_WIDTH-1:0]     qx_q, qx_d, qy_q, qy_d, qz_q, qz_d;
   logic                   busy_q, busy_d, done_q, done_d, tmo_q, tmo_d, vin_q, vin_d;
   logic [A_WIDTH-1:0]     a1_q, a1_d, a2_q, a2_d, a3_q, a3_d;
   logic [B_WIDTH-1:0]     b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;

   always_comb begin
      state_d = state_q;
      mat_d   = mat_q;
      px_d    = px_q;
      py_d    = py_q;
      pz_d    = pz_q;
      issue_d = issue_q;
      res_d   = res_q;
      wait_d  = wait_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      qx_d    = qx_q;
      qy_d    = qy_q;
      qz_d    = qz_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      vin_d   = 1'b0;
      a1_d    = '0;
      a2_d    = '0;
      a3_d    = '0;
      b1_d    = '0;
      b2_d    = '0;
      b3_d    = '0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mat_d   = R_flat;
               px_d    = px;
               py_d    = py;
               pz_d    = pz;
               busy_d  = 1'b1;
               issue_d = '0;
               res_d   = '0;
               wait_d  = '0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE, ST_COLLECT: begin
            wait_d = wait_q + W_WIDTH'(1);
            if (state_q == ST_ISSUE) begin
               vin_d   = 1'b1;
               a1_d    = elem(mat_q, 32'(issue_q), 0);
               a2_d    = elem(mat_q, 32'(issue_q), 1);
               a3_d    = elem(mat_q, 32'(issue_q), 2);
               b1_d    = px_q;
               b2_d    = py_q;
               b3_d    = pz_q;
               issue_d = issue_q + 2'd1;
               if (issue_q == 2'd2) state_d = ST_COLLECT;
            end
            // Results are staged so a timeout leaves the visible q outputs intact
            if (dp_validOut && res_q == 2'd2) begin
               qx_d    = r0_q;
               qy_d    = r1_q;
               qz_d    = dp_dp;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (wait_q == W_WIDTH'(MAX_WAIT)) begin
               tmo_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (dp_validOut) begin
               if (res_q == 2'd0) r0_d = dp_dp;
               else               r1_d = dp_dp;
               res_d = res_q + 2'd1;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         mat_q   <= '0;
         px_q    <= '0;
         py_q    <= '0;
         pz_q    <= '0;
         issue_q <= '0;
         res_q   <= '0;
         wait_q  <= '0;
         r0_q    <= '0;
         r1_q    <= '0;
         qx_q    <= '0;
         qy_q    <= '0;
         qz_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         vin_q   <= 1'b0;
         a1_q    <= '0;
         a2_q    <= '0;
         a3_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         b3_q    <= '0;
      end else begin
         state_q <= state_d;
         mat_q   <= mat_d;
         px_q    <= px_d;
         py_q    <= py_d;
         pz_q    <= pz_d;
         issue_q <= issue_d;
         res_q   <= res_d;
         wait_q  <= wait_d;
         r0_q    <= r0_d;
         r1_q    <= r1_d;
         qx_q    <= qx_d;
         qy_q    <= qy_d;
         qz_q    <= qz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         vin_q   <= vin_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         a3_q    <= a3_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         b3_q    <= b3_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign timeout    = tmo_q;
   assign qx         = qx_q;
   assign qy         = qy_q;
   assign qz         = qz_q;
   assign dp_validIn = vin_q;
   assign dp_A1      = a1_q;
   assign dp_A2      = a2_q;
   assign dp_A3      = a3_q;
   assign dp_B1      = b1_q;
   assign dp_B2      = b2_q;
   assign dp_B3      = b3_q;

endmodule

// File: tb/tb_mat3_vec_seq.sv
// Directed bench for mat3_vec_seq, paired with a two-stage behavioural
// stand-in for dp_3x1 (products, then sum) sharing the same reset.
module tb_mat3_vec_seq;

   localparam int AW = 18;
   localparam int BW = 18;
   localparam int PW = AW + BW + 1;
   localparam int MW = 64;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [9*AW-1:0] R_flat = '0;
   logic [BW-1:0] px = '0, py = '0, pz = '0;
   logic          busy, done, timeout;
   logic [PW-1:0] qx, qy, qz;
   logic          dp_validIn;
   logic [AW-1:0] dp_A1, dp_A2, dp_A3;
   logic [BW-1:0] dp_B1, dp_B2, dp_B3;
   logic [PW-1:0] dp_dp;
   logic          dp_validOut;

   logic          quiet = 1'b0;
   logic          stray = 1'b0;
   logic          m_v1, m_v2;
   logic signed [PW-1:0] m_s1, m_out;

   int cyc = 0;
   int checks = 0, passes = 0;
   int n_valid, n_done, n_tmo, n_zero_bad, c_first, c_tmo;
   logic tmo_busy;

   localparam logic [PW-1:0] Q_5  = 37'h0014000000;
   localparam logic [PW-1:0] Q_M3 = 37'h1FF4000000;
   localparam logic [PW-1:0] Q_75 = 37'h001E000000;

   mat3_vec_seq #(.A_WIDTH(AW), .B_WIDTH(BW), .MAX_WAIT(MW)) dut (
      .clock(clock), .reset(reset), .start(start), .R_flat(R_flat),
      .px(px), .py(py), .pz(pz), .busy(busy), .done(done), .timeout(timeout),
      .qx(qx), .qy(qy), .qz(qz), .dp_validIn(dp_validIn),
      .dp_A1(dp_A1), .dp_A2(dp_A2), .dp_A3(dp_A3),
      .dp_B1(dp_B1), .dp_B2(dp_B2), .dp_B3(dp_B3),
      .dp_dp(dp_dp), .dp_validOut(dp_validOut)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   function automatic logic signed [PW-1:0] smul(input logic signed [AW-1:0] a,
                                                 input logic signed [BW-1:0] b);
      logic signed [PW-1:0] ae, be;
      ae = PW'(a);
      be = PW'(b);
      return ae * be;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         m_v1  <= 1'b0;
         m_v2  <= 1'b0;
         m_s1  <= '0;
         m_out <= '0;
      end else begin
         m_v1  <= dp_validIn;
         m_s1  <= smul(dp_A1, dp_B1) + smul(dp_A2, dp_B2) + smul(dp_A3, dp_B3);
         m_v2  <= m_v1;
         m_out <= m_s1;
      end
   end

   assign dp_validOut = (m_v2 & ~quiet) | stray;
   assign dp_dp       = m_out;

   task automatic clear_counts();
      n_valid = 0; n_done = 0; n_tmo = 0; n_zero_bad = 0;
      c_first = -1; c_tmo = -1; tmo_busy = 1'b1;
   endtask

   task automatic tick();
      @(negedge clock);
      if (dp_validIn) begin
         n_valid++;
         if (c_first < 0) c_first = cyc;
      end else if ({dp_A1, dp_A2, dp_A3, dp_B1, dp_B2, dp_B3} != '0) begin
         n_zero_bad++;
      end
      if (done) n_done++;
      if (timeout) begin
         n_tmo++;
         c_tmo = cyc;
         tmo_busy = busy;
      end
   endtask

   task automatic set_mat(input logic [AW-1:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
      R_flat = {e8, e7, e6, e5, e4, e3, e2, e1, e0};
   endtask

   task automatic set_identity();
      set_mat(18'h10000, 0, 0, 0, 18'h10000, 0, 0, 0, 18'h10000);
      px = 18'h01400; py = 18'h3F400; pz = '0;
   endtask

   // 18'h20000 would read as -2.0 in signed Q2.16; 1.5 keeps row 0 positive.
   task automatic set_permuted();
      set_mat(18'h18000, 0, 0, 0, 0, 18'h10000, 0, 18'h10000, 0);
      px = 18'h01400; py = 18'h3F400; pz = '0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b1;
      set_identity();
      repeat (3) tick();
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
      checks++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout); else passes++;
      checks++; if (dp_validIn !== 1'b0) $display("FAIL reset_validIn got %b want 0", dp_validIn); else passes++;
      checks++; if ({qx, qy, qz} !== '0) $display("FAIL reset_q got %h %h %h want 0", qx, qy, qz); else passes++;
      checks++; if (dp_A1 !== '0) $display("FAIL reset_A1 got %h want 0", dp_A1); else passes++;
      reset = 1'b0; start = 1'b0;
      tick();
   endtask

   task automatic test_identity();
      set_identity();
      clear_counts();
      pulse_start();
      repeat (20) tick();
      checks++; if (n_valid != 3) $display("FAIL ident_valid_cycles got %0d want 3", n_valid); else passes++;
      checks++; if (n_done != 1) $display("FAIL ident_done_count got %0d want 1", n_done); else passes++;
      checks++; if (n_zero_bad != 0) $display("FAIL ident_idle_operands got %0d nonzero cycles want 0", n_zero_bad); else passes++;
      checks++; if (qx !== Q_5) $display("FAIL ident_qx got %h want %h", qx, Q_5); else passes++;
      checks++; if (qy !== Q_M3) $display("FAIL ident_qy got %h want %h", qy, Q_M3); else passes++;
      checks++; if (qz !== '0) $display("FAIL ident_qz got %h want 0", qz); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL ident_busy_end got %b want 0", busy); else passes++;
   endtask

   task automatic test_row_order();
      set_permuted();
      clear_counts();
      pulse_start();
      repeat (20) tick();
      checks++; if (n_done != 1) $display("FAIL rows_done_count got %0d want 1", n_done); else passes++;
      checks++; if (qx !== Q_75) $display("FAIL rows_qx got %h want %h", qx, Q_75); else passes++;
      checks++; if (qy !== '0) $display("FAIL rows_qy got %h want 0", qy); else passes++;
      checks++; if (qz !== Q_M3) $display("FAIL rows_qz got %h want %h", qz, Q_M3); else passes++;
   endtask

   task automatic test_ignored_start();
      set_identity();
      clear_counts();
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      pulse_start();
      tick();
      pulse_start();
      tick();
      start = 1'b1;
      for (int i = 0; i < 25; i++) begin
         tick();
         start = done;
      end
      start = 1'b0;
      checks++; if (n_valid != 3) $display("FAIL ign_valid_cycles got %0d want 3", n_valid); else passes++;
      checks++; if (n_done != 1) $display("FAIL ign_done_count got %0d want 1", n_done); else passes++;
      checks++; if (qx !== Q_5) $display("FAIL ign_qx got %h want %h", qx, Q_5); else passes++;
      checks++; if (qy !== Q_M3) $display("FAIL ign_qy got %h want %h", qy, Q_M3); else passes++;
      checks++; if (qz !== '0) $display("FAIL ign_qz got %h want 0", qz); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL ign_busy_end got %b want 0", busy); else passes++;
   endtask

   task automatic test_timeout();
      set_permuted();
      clear_counts();
      quiet = 1'b1;
      pulse_start();
      repeat (100) tick();
      quiet = 1'b0;
      checks++; if (n_tmo != 1) $display("FAIL tmo_pulses got %0d want 1", n_tmo); else passes++;
      checks++; if (c_tmo - c_first != MW) $display("FAIL tmo_delay got %0d want %0d", c_tmo - c_first, MW); else passes++;
      checks++; if (tmo_busy !== 1'b0) $display("FAIL tmo_busy got %b want 0", tmo_busy); else passes++;
      checks++; if (n_done != 0) $display("FAIL tmo_done_count got %0d want 0", n_done); else passes++;
      checks++; if (n_valid != 3) $display("FAIL tmo_valid_cycles got %0d want 3", n_valid); else passes++;
      checks++; if ({qx, qy, qz} !== {Q_5, Q_M3, 37'h0})
         $display("FAIL tmo_q_held got %h %h %h want %h %h 0", qx, qy, qz, Q_5, Q_M3);
      else passes++;
   endtask

   task automatic test_reset_mid_run();
      bit seen_valid;
      set_identity();
      clear_counts();
      seen_valid = 1'b0;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (dp_validIn) seen_valid = 1'b1;
         else if (seen_valid) break;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (busy !== 1'b0 || dp_validIn !== 1'b0)
         $display("FAIL midrst_idle got busy=%b validIn=%b want 0 0", busy, dp_validIn);
      else passes++;
      checks++; if ({qx, qy, qz} !== '0) $display("FAIL midrst_q got %h %h %h want 0", qx, qy, qz); else passes++;
      repeat (10) tick();
      checks++; if (n_done != 0) $display("FAIL midrst_aborted_done got %0d want 0", n_done); else passes++;
      set_permuted();
      clear_counts();
      pulse_start();
      repeat (20) tick();
      checks++; if (n_done != 1) $display("FAIL midrst_rerun_done got %0d want 1", n_done); else passes++;
      checks++; if ({qx, qy, qz} !== {Q_75, 37'h0, Q_M3})
         $display("FAIL midrst_rerun_q got %h %h %h want %h 0 %h", qx, qy, qz, Q_75, Q_M3);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_row_order();
      test_ignored_start();
      test_timeout();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
